// File: rtl/vga_sync_timing_pkg.sv
// Shared 640x480@60 raster constants, the counter width and the output bundle
// used by the VGA sync timing generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_WIDTH         = 640;
    localparam int unsigned VGA_HEIGHT        = 480;
    localparam int unsigned VGA_H_FRONT_PORCH = 16;
    localparam int unsigned VGA_H_SYNC_WIDTH  = 96;
    localparam int unsigned VGA_H_BACK_PORCH  = 48;
    localparam int unsigned VGA_V_FRONT_PORCH = 10;
    localparam int unsigned VGA_V_SYNC_WIDTH  = 2;
    localparam int unsigned VGA_V_BACK_PORCH  = 33;

    typedef struct packed {
        logic       screen_end;
        logic       active;
        logic       h_sync;
        logic       v_sync;
        logic [9:0] x;
        logic [8:0] y;
    } vga_out_t;

    // Idle levels: syncs deasserted (high), no video, coordinates parked at 0.
    localparam vga_out_t VGA_OUT_RESET = '{
        screen_end: 1'b0,
        active:     1'b0,
        h_sync:     1'b1,
        v_sync:     1'b1,
        x:          '0,
        y:          '0
    };

    function automatic logic in_window(input logic [CNT_W-1:0] value,
                                       input int unsigned      lo,
                                       input int unsigned      hi);
        return (value >= CNT_W'(lo)) && (value < CNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_timing_axis_counter.sv
// Wrapping modulo-N counter with count enable and a terminal-count flag; one
// instance per raster axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MODULUS = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VALUE = CNT_W'(MODULUS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal count is not gated by en so it can feed the next axis' enable.
    assign last  = (count_q == LAST_VALUE);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster timing generator (640x480@60 by default) from a 25 MHz pixel clock.
// Define VGA_SYNC_REG_OUT_EN to register all outputs (one extra clk25 of latency).
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned WIDTH         = VGA_WIDTH,
    parameter int unsigned HEIGHT        = VGA_HEIGHT,
    parameter int unsigned H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_WIDTH  = VGA_H_SYNC_WIDTH,
    parameter int unsigned H_BACK_PORCH  = VGA_H_BACK_PORCH,
    parameter int unsigned V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_WIDTH  = VGA_V_SYNC_WIDTH,
    parameter int unsigned V_BACK_PORCH  = VGA_V_BACK_PORCH
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       screenEnd,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic [9:0] x,
    output logic [8:0] y
);

    localparam int unsigned H_TOTAL = WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int unsigned H_SYNC_START = WIDTH + H_FRONT_PORCH;
    localparam int unsigned V_SYNC_START = HEIGHT + V_FRONT_PORCH;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_last;
    logic             v_last_unused;

    vga_out_t out_d;
    vga_out_t out_s;

    vga_axis_counter #(.MODULUS(H_TOTAL)) u_h_counter (
        .clk   (clk25),
        .rst   (reset),
        .en    (1'b1),
        .count (h_count),
        .last  (h_last)
    );

    vga_axis_counter #(.MODULUS(V_TOTAL)) u_v_counter (
        .clk   (clk25),
        .rst   (reset),
        .en    (h_last),
        .count (v_count),
        .last  (v_last_unused)
    );

    // Reset gates the decode so outputs idle while the counters sit at zero.
    always_comb begin
        out_d = VGA_OUT_RESET;
        if (!reset) begin
            out_d.active     = (h_count < CNT_W'(WIDTH)) && (v_count < CNT_W'(HEIGHT));
            out_d.h_sync     = !in_window(h_count, H_SYNC_START, H_SYNC_START + H_SYNC_WIDTH);
            out_d.v_sync     = !in_window(v_count, V_SYNC_START, V_SYNC_START + V_SYNC_WIDTH);
            out_d.screen_end = (h_count == '0) && (v_count == CNT_W'(HEIGHT));
            out_d.x          = h_count;
            out_d.y          = v_count[8:0];
        end
    end

`ifdef VGA_SYNC_REG_OUT_EN
    vga_out_t out_q;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            out_q <= VGA_OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_s = out_q;
`else
    assign out_s = out_d;
`endif

    assign screenEnd = out_s.screen_end;
    assign active    = out_s.active;
    assign hSync     = out_s.h_sync;
    assign vSync     = out_s.v_sync;
    assign x         = out_s.x;
    assign y         = out_s.y;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Self-checking bench: a full-size and a shrunken-timing instance compared every
// cycle against an arithmetic raster model, plus hand-computed event timings.
module tb_vga_sync_timing;

`ifdef VGA_SYNC_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk25 = 1'b0;
    logic reset = 1'b1;
    always #20 clk25 = ~clk25;

    logic       f_se, f_act, f_hs, f_vs;
    logic [9:0] f_x;
    logic [8:0] f_y;
    logic       s_se, s_act, s_hs, s_vs;
    logic [9:0] s_x;
    logic [8:0] s_y;

    vga_sync_timing u_full (
        .clk25     (clk25),
        .reset     (reset),
        .screenEnd (f_se),
        .active    (f_act),
        .hSync     (f_hs),
        .vSync     (f_vs),
        .x         (f_x),
        .y         (f_y)
    );

    // Small raster: 30 clocks/line, 21 lines/frame, 630 clocks/frame.
    vga_sync_timing #(
        .WIDTH        (16),
        .HEIGHT       (12),
        .H_FRONT_PORCH(4),
        .H_SYNC_WIDTH (6),
        .H_BACK_PORCH (4),
        .V_FRONT_PORCH(3),
        .V_SYNC_WIDTH (2),
        .V_BACK_PORCH (4)
    ) u_small (
        .clk25     (clk25),
        .reset     (reset),
        .screenEnd (s_se),
        .active    (s_act),
        .hSync     (s_hs),
        .vSync     (s_vs),
        .x         (s_x),
        .y         (s_y)
    );

    int checks = 0;
    int failures = 0;
    int t = 0;       // rising edges since the last reset release
    int phase = 0;   // 0 before the mid-frame reset, 1 after

    logic pf_act = 1'b0, pf_hs = 1'b1, ps_vs = 1'b1, ps_se = 1'b0;
    int f_act_fall = -1, f_fall_x = -1, f_act_rise = -1;
    int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1;
    int vs_fall1 = -1, vs_rise1 = -1;
    int se_in_reset = 0, se_wide = 0, se_badpos = 0;
    int se_t0[$];
    int se_t1[$];

    function automatic logic [22:0] model(input int tt, input logic rst,
                                          input int w, input int hfp, input int hsw, input int hbp,
                                          input int h, input int vfp, input int vsw, input int vbp);
        int   ht, vt, te, hc, vc;
        logic se, act, hs, vs;
        ht = w + hfp + hsw + hbp;
        vt = h + vfp + vsw + vbp;
        te = tt - LAT;
        if (rst || te < 0) return {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0};
        hc  = te % ht;
        vc  = (te / ht) % vt;
        act = (hc < w) && (vc < h);
        hs  = !((hc >= w + hfp) && (hc < w + hfp + hsw));
        vs  = !((vc >= h + vfp) && (vc < h + vfp + vsw));
        se  = (hc == 0) && (vc == h);
        return {se, act, hs, vs, 10'(hc), 9'(vc)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic compare_all();
        logic [22:0] g, w;
        w = model(t, reset, 640, 16, 96, 48, 480, 10, 2, 33);
        g = {f_se, f_act, f_hs, f_vs, f_x, f_y};
        checks++;
        if (g !== w) begin
            failures++;
            $display("FAIL full_raster t=%0d got=%h want=%h", t, g, w);
        end
        w = model(t, reset, 16, 4, 6, 4, 12, 3, 2, 4);
        g = {s_se, s_act, s_hs, s_vs, s_x, s_y};
        checks++;
        if (g !== w) begin
            failures++;
            $display("FAIL small_raster t=%0d got=%h want=%h", t, g, w);
        end
    endtask

    task automatic track();
        if (phase == 0) begin
            if (pf_act && !f_act && f_act_fall < 0) begin
                f_act_fall = t;
                f_fall_x   = int'(f_x);
            end
            if (!pf_act && f_act && f_act_fall >= 0 && f_act_rise < 0) f_act_rise = t;
            if (pf_hs && !f_hs) begin
                if (hs_fall1 < 0) hs_fall1 = t;
                else if (hs_fall2 < 0) hs_fall2 = t;
            end
            if (!pf_hs && f_hs && hs_rise1 < 0) hs_rise1 = t;
            if (ps_vs && !s_vs && vs_fall1 < 0) vs_fall1 = t;
            if (!ps_vs && s_vs && vs_rise1 < 0) vs_rise1 = t;
        end
        if (s_se) begin
            if (reset) se_in_reset++;
            else if (phase == 0) se_t0.push_back(t);
            else se_t1.push_back(t);
            if (!(s_x == 10'd0 && s_y == 9'd12)) se_badpos++;
            if (ps_se) se_wide++;
        end
        pf_act = f_act;
        pf_hs  = f_hs;
        ps_vs  = s_vs;
        ps_se  = s_se;
    endtask

    task automatic step();
        @(posedge clk25);
        if (!reset) t++;
        @(negedge clk25);
        compare_all();
        track();
    endtask

    initial begin
        repeat (3) step();
        chk("reset_levels", {29'd0, f_act, f_hs, f_vs}, 32'b011);

        reset = 1'b0;
        #1;
        compare_all();
        chk("release_xy", {f_x, f_y}, 32'd0);
        chk("release_active", {31'd0, f_act}, (LAT == 0) ? 32'd1 : 32'd0);

        repeat (2050) step();
        chk("pre_reset_xy", {s_x, s_y}, {10'(10 - LAT), 9'd5});

        reset = 1'b1;
        t     = 0;
        phase = 1;
        #1;
        compare_all();
        chk("reset_forced", {28'd0, s_act, s_hs, s_vs, s_se}, 32'b0110);
        repeat (2) step();

        reset = 1'b0;
        #1;
        compare_all();
        chk("rerelease_xy", {s_x, s_y}, 32'd0);
        repeat (400) step();

        chk("act_fall_t", f_act_fall, 640 + LAT);
        chk("act_fall_x", f_fall_x, 640);
        chk("act_rise_t", f_act_rise, 800 + LAT);
        chk("hs_fall_t", hs_fall1, 656 + LAT);
        chk("hs_low_len", hs_rise1 - hs_fall1, 96);
        chk("hs_period", hs_fall2 - hs_fall1, 800);
        chk("vs_fall_t", vs_fall1, 450 + LAT);
        chk("vs_low_len", vs_rise1 - vs_fall1, 60);
        chk("se_count_3frames", se_t0.size(), 3);
        foreach (se_t0[i]) chk("se_time", se_t0[i], 360 + LAT + 630 * i);
        chk("se_wide", se_wide, 0);
        chk("se_badpos", se_badpos, 0);
        chk("se_in_reset", se_in_reset, 0);
        chk("se_after_reset_count", se_t1.size(), 1);
        chk("se_after_reset_t", (se_t1.size() > 0) ? se_t1[0] : -1, 360 + LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
